hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_pkg.sv | 29 ++
 rtl/hilo_unit_div_core.sv | 70 +++++++
 rtl/hilo_unit.sv | 175 +++++++++++++++++
 tb/tb_hilo_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_pkg
// Description : Shared types for the HI/LO unit: request codes, FSM states
//               and the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_WPROD = 3'd1,
        OP_MTHI  = 3'd2,
        OP_MTLO  = 3'd3,
        OP_DIV   = 3'd4,
        OP_DIVU  = 3'd5
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } hilo_state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_unit_div_core.sv
`default_nettype none
// ============================================================================
// Module      : div_core
// Description : Iterative unsigned restoring divider, one quotient bit per
//               step. Built only when HILO_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef HILO_DIV_EN
module div_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    // Dividend bits shift out of the quotient register into the remainder.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_count <= '0;
        end else if (start) begin
            r_quo   <= dividend;
            r_rem   <= '0;
            r_dvs   <= divisor;
            r_count <= '0;
        end else if (step) begin
            r_count <= r_count + 1'b1;
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign last      = (r_count == c_LAST);
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`endif
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_unit
// Description : Architectural HI/LO registers with product/move writes and an
//               optional multi-cycle divider enabled by macro HILO_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] alu_lo,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             w_accept;
    logic             w_fix_wr;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_accept = op_valid && op_ready;

`ifdef HILO_DIV_EN
    hilo_state_e      r_state;
    hilo_state_e      w_next;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic             w_is_div;
    logic             w_is_any_div;
    logic             w_div_acc;
    logic             w_start;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_is_div     = (op == OP_DIV);
    assign w_is_any_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_div_acc    = w_accept && w_is_any_div;

    // Signed divide runs on magnitudes; the most negative value maps onto
    // itself, which is the correct unsigned magnitude.
    assign w_rs_mag = (w_is_div && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_rt_mag = (w_is_div && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .step      (w_step),
        .dividend  (w_rs_mag),
        .divisor   (w_rt_mag),
        .last      (w_last),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_div_acc) begin
                r_dbz   <= (rt_val == '0);
                r_neg_q <= w_is_div && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                r_neg_r <= w_is_div && rs_val[WIDTH-1];
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        op_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        w_start  = 1'b0;
        w_step   = 1'b0;
        w_fix_wr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid && w_is_any_div) begin
                    if (rt_val == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_start = 1'b1;
                        w_next  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                busy     = 1'b1;
                w_fix_wr = 1'b1;
                w_next   = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_fix_hi    = r_neg_r ? -w_rem : w_rem;
    assign w_fix_lo    = r_neg_q ? -w_quo : w_quo;
    assign div_by_zero = r_dbz;
`else
    logic w_unused;

    assign op_ready    = 1'b1;
    assign busy        = 1'b0;
    assign done        = 1'b0;
    assign div_by_zero = 1'b0;
    assign w_fix_wr    = 1'b0;
    assign w_fix_hi    = '0;
    assign w_fix_lo    = '0;
    assign w_unused    = ^rt_val;
`endif

    // Divide write-back and new requests are exclusive: requests need IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix_wr) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else if (w_accept) begin
            case (op)
                OP_WPROD: begin
                    r_hi <= alu_hi;
                    r_lo <= alu_lo;
                end
                OP_MTHI: r_hi <= rs_val;
                OP_MTLO: r_lo <= rs_val;
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_unit
// Description : Directed self-checking bench for hilo_unit; the divide
//               vectors apply when HILO_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;
    import hilo_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] alu_lo;
    logic [W-1:0] alu_hi;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         op_ready;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    hilo_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op          (op),
        .alu_lo      (alu_lo),
        .alu_hi      (alu_hi),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .op_ready    (op_ready),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        tick();
        op_valid = 1'b0;
        op       = OP_NOP;
    endtask

    task automatic wprod(input logic [W-1:0] h, input logic [W-1:0] l);
        alu_hi = h;
        alu_lo = l;
        issue(OP_WPROD, '0, '0);
    endtask

    // Counts cycles after the accept edge until done; also flags any HI/LO
    // change seen before done.
    task automatic wait_done(input int start, output int n, output logic moved);
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        h0    = hi;
        l0    = lo;
        n     = start;
        moved = 1'b0;
        while (!done && n < 100) begin
            if (hi !== h0 || lo !== l0) moved = 1'b1;
            tick();
            n++;
        end
    endtask

    initial begin
        int   n;
        int   pulses;
        logic moved;

        rst      = 1'b1;
        op_valid = 1'b0;
        op       = OP_NOP;
        alu_lo   = '0;
        alu_hi   = '0;
        rs_val   = '0;
        rt_val   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_ready", op_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz", div_by_zero, 0);

        wprod(32'h1, 32'h2);
        check("wprod_hi", hi, 32'h1);
        check("wprod_lo", lo, 32'h2);
        check("wprod_ready", op_ready, 1);

        issue(OP_MTHI, 32'h1234, '0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_lo", lo, 32'h2);
        issue(OP_MTLO, 32'h55, '0);
        check("mtlo_hi", hi, 32'h1234);
        check("mtlo_lo", lo, 32'h55);

`ifdef HILO_DIV_EN
        // 7 / -2 = -3 rem 1
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        check("div1_busy", busy, 1);
        check("div1_ready", op_ready, 0);
        wait_done(1, n, moved);
        check("div1_latency", n, 34);
        check("div1_hilo_still", moved, 0);
        check("div1_lo", lo, 32'hFFFF_FFFD);
        check("div1_hi", hi, 32'h1);
        tick();
        check("div1_done_pulse", done, 0);
        check("div1_idle", op_ready, 1);

        // DIVU with an MTLO attempted mid-division
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd16);
        tick();
        tick();
        tick();
        issue(OP_MTLO, 32'h99, '0);
        check("divu_mtlo_ignored", lo, 32'hFFFF_FFFD);
        wait_done(5, n, moved);
        check("divu_latency", n, 34);
        check("divu_lo", lo, 32'h0FFF_FFFF);
        check("divu_hi", hi, 32'hF);
        check("divu_dbz", div_by_zero, 0);
        tick();

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, n, moved);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        check("ovf_dbz", div_by_zero, 0);
        tick();

        // -7 / 2 = -3 rem -1
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, n, moved);
        check("negdvd_lo", lo, 32'hFFFF_FFFD);
        check("negdvd_hi", hi, 32'hFFFF_FFFF);
        tick();

        issue(OP_MTHI, 32'hAA, '0);
        issue(OP_MTLO, 32'hBB, '0);
        issue(OP_DIV, 32'd5, 32'd0);
        check("dz_done", done, 1);
        check("dz_flag", div_by_zero, 1);
        check("dz_hi", hi, 32'hAA);
        check("dz_lo", lo, 32'hBB);
        tick();
        check("dz_done_once", done, 0);
        check("dz_flag_held", div_by_zero, 1);

        issue(OP_DIVU, 32'd10, 32'd3);
        check("dz_flag_cleared", div_by_zero, 0);
        wait_done(1, n, moved);
        check("divu2_lo", lo, 32'd3);
        check("divu2_hi", hi, 32'd1);
        tick();

        // Reset during cycle 10 of a divide
        issue(OP_DIV, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", op_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        check("abort_no_done", pulses, 0);
`else
        issue(OP_MTHI, 32'hAA, '0);
        issue(OP_MTLO, 32'hBB, '0);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        check("nodiv_busy", busy, 0);
        check("nodiv_ready", op_ready, 1);
        check("nodiv_hi", hi, 32'hAA);
        check("nodiv_lo", lo, 32'hBB);
        issue(OP_DIVU, 32'd5, 32'd0);
        check("nodiv_dbz", div_by_zero, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy || !op_ready) pulses++;
            tick();
        end
        check("nodiv_quiet", pulses, 0);
        check("nodiv_hi_after", hi, 32'hAA);
        check("nodiv_lo_after", lo, 32'hBB);
`endif

        // Reset wins over a same-cycle request
        wprod(32'h5, 32'h6);
        check("pre_rst_hi", hi, 32'h5);
        rst      = 1'b1;
        op_valid = 1'b1;
        op       = OP_WPROD;
        alu_hi   = 32'h7;
        alu_lo   = 32'h8;
        tick();
        rst      = 1'b0;
        op_valid = 1'b0;
        op       = OP_NOP;
        check("rst_prio_hi", hi, 32'h0);
        check("rst_prio_lo", lo, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
